// File: rtl/ff_scalar_mul_small_if.sv
// Request and finite-field-adder handshake bundle for ff_scalar_mul_small.
// The slave modport is the multiplier; master is whatever drives requests and hosts the adder.
interface ff_scalar_mul_small_if #(
   parameter int KW = 8
);
   logic          start;
   logic [KW-1:0] k;
   logic [254:0]  x;
   logic [254:0]  out;
   logic          done;
   logic          busy;
   logic          ffa_start;
   logic [254:0]  ffa_a;
   logic [254:0]  ffa_b;
   logic [254:0]  ffa_out;
   logic          ffa_done;

   modport slave (
      input  start, k, x, ffa_out, ffa_done,
      output out, done, busy, ffa_start, ffa_a, ffa_b
   );

   modport master (
      output start, k, x, ffa_out, ffa_done,
      input  out, done, busy, ffa_start, ffa_a, ffa_b
   );
endinterface

// File: rtl/ff_scalar_mul_small.sv
// out = (k * x) mod (2^255 - 19) by MSB-first double-and-add, with every modular
// addition delegated to the external field adder over its start/done handshake.
module ff_scalar_mul_small #(
   parameter int KW = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   ff_scalar_mul_small_if.slave     bus
);
   localparam int IW = (KW > 1) ? $clog2(KW) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(KW - 1);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      DBL_ISSUE,
      DBL_WAIT,
      ADD_ISSUE,
      ADD_WAIT,
      FIN
   } state_t;

   state_t        state_reg;
   logic [254:0]  acc_reg;
   logic [254:0]  xreg_reg;
   logic [KW-1:0] kreg_reg;
   logic [IW-1:0] idx_reg;
   logic [254:0]  out_reg;
   logic          done_reg;
   logic          busy_reg;
   logic          ffa_start_reg;
   logic [254:0]  ffa_a_reg;
   logic [254:0]  ffa_b_reg;

   logic bit_cur;
   logic idx_last;

   assign bit_cur  = kreg_reg[idx_reg];
   assign idx_last = (idx_reg == '0);

   assign bus.out       = out_reg;
   assign bus.done      = done_reg;
   assign bus.busy      = busy_reg;
   assign bus.ffa_start = ffa_start_reg;
   assign bus.ffa_a     = ffa_a_reg;
   assign bus.ffa_b     = ffa_b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         xreg_reg      <= '0;
         kreg_reg      <= '0;
         idx_reg       <= IDX_TOP;
         out_reg       <= '0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         ffa_start_reg <= 1'b0;
         ffa_a_reg     <= '0;
         ffa_b_reg     <= '0;
      end else begin
         // The adder start strobe is high only in the cycle after an ISSUE state.
         ffa_start_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  kreg_reg  <= bus.k;
                  xreg_reg  <= bus.x;
                  acc_reg   <= '0;
                  idx_reg   <= IDX_TOP;
                  busy_reg  <= 1'b1;
                  state_reg <= SCAN;
               end
            end

            SCAN: begin
               if (bit_cur) begin
                  acc_reg <= xreg_reg;
                  if (idx_last) begin
                     state_reg <= FIN;
                  end else begin
                     idx_reg   <= idx_reg - IW'(1);
                     state_reg <= DBL_ISSUE;
                  end
               end else if (idx_last) begin
                  state_reg <= FIN;
               end else begin
                  idx_reg <= idx_reg - IW'(1);
               end
            end

            DBL_ISSUE: begin
               ffa_a_reg     <= acc_reg;
               ffa_b_reg     <= acc_reg;
               ffa_start_reg <= 1'b1;
               state_reg     <= DBL_WAIT;
            end

            DBL_WAIT: begin
               if (bus.ffa_done) begin
                  acc_reg <= bus.ffa_out;
                  if (bit_cur) begin
                     state_reg <= ADD_ISSUE;
                  end else if (idx_last) begin
                     state_reg <= FIN;
                  end else begin
                     idx_reg   <= idx_reg - IW'(1);
                     state_reg <= DBL_ISSUE;
                  end
               end
            end

            ADD_ISSUE: begin
               ffa_a_reg     <= acc_reg;
               ffa_b_reg     <= xreg_reg;
               ffa_start_reg <= 1'b1;
               state_reg     <= ADD_WAIT;
            end

            ADD_WAIT: begin
               if (bus.ffa_done) begin
                  acc_reg <= bus.ffa_out;
                  if (idx_last) begin
                     state_reg <= FIN;
                  end else begin
                     idx_reg   <= idx_reg - IW'(1);
                     state_reg <= DBL_ISSUE;
                  end
               end
            end

            FIN: begin
               out_reg   <= acc_reg;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ff_scalar_mul_small.sv
// Randomised check of ff_scalar_mul_small against wide-arithmetic (k*x) mod p,
// with a behavioural field adder answering each start six cycles later.
module tb_ff_scalar_mul_small;
   localparam int KW = 8;
   localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ff_scalar_mul_small_if #(.KW(KW)) bus ();

   ff_scalar_mul_small #(.KW(KW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural field adder: latches operands on start, answers later.
   logic [254:0] lat_a;
   logic [254:0] lat_b;
   int           ffa_cnt = 0;
   bit           pending = 1'b0;
   int           stab_viol = 0;
   int           overlap_viol = 0;
   int           pulse_cnt = 0;
   bit           cnt_clr = 1'b0;

   function automatic logic [254:0] add_mod(input logic [254:0] a, input logic [254:0] b);
      logic [255:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= P) s = s - P;
      return s[254:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ffa_cnt      <= 0;
         pending      <= 1'b0;
         bus.ffa_done <= 1'b0;
         bus.ffa_out  <= '0;
      end else begin
         bus.ffa_done <= 1'b0;
         if (bus.ffa_start) begin
            if (pending) overlap_viol <= overlap_viol + 1;
            pending <= 1'b1;
            lat_a   <= bus.ffa_a;
            lat_b   <= bus.ffa_b;
            ffa_cnt <= 6;
         end else if (pending) begin
            if (bus.ffa_a !== lat_a || bus.ffa_b !== lat_b) stab_viol <= stab_viol + 1;
            if (ffa_cnt == 1) begin
               bus.ffa_done <= 1'b1;
               bus.ffa_out  <= add_mod(lat_a, lat_b);
               pending      <= 1'b0;
            end
            ffa_cnt <= ffa_cnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (cnt_clr) pulse_cnt <= 0;
      else if (bus.ffa_start) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [254:0] ref_mul(input logic [KW-1:0] k, input logic [254:0] x);
      logic [271:0] prod;
      logic [271:0] p_wide;
      p_wide = 272'(P);
      prod   = 272'(k) * 272'(x);
      prod   = prod % p_wide;
      return prod[254:0];
   endfunction

   function automatic int ref_ops(input logic [KW-1:0] k);
      int msb = 0;
      int pc  = 0;
      for (int i = 0; i < KW; i++) begin
         if (k[i]) begin
            msb = i;
            pc++;
         end
      end
      return (k == '0) ? 0 : msb + pc - 1;
   endfunction

   function automatic logic [254:0] rand_fe();
      logic [255:0] r;
      logic [254:0] v;
      logic [254:0] pn;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      v  = r[254:0];
      pn = P[254:0];
      if (v >= pn) v = v - pn;
      return v;
   endfunction

   task automatic run_op(input logic [KW-1:0] k, input logic [254:0] x, input bit interfere);
      logic [254:0] exp_out;
      int           exp_ops;
      int           n;
      exp_out = ref_mul(k, x);
      exp_ops = ref_ops(k);
      @(negedge clk);
      bus.start = 1'b1;
      bus.k     = k;
      bus.x     = x;
      cnt_clr   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cnt_clr   = 1'b0;
      bus.k     = KW'($urandom);
      bus.x     = rand_fe();
      check("busy_after_start", 272'(bus.busy), 272'(1'b1));
      if (interfere) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.k     = KW'(5);
         bus.x     = 255'd9;
         @(negedge clk);
         bus.start = 1'b0;
      end
      n = 0;
      while (bus.done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_in_time", 272'(n < 3000), 272'(1'b1));
      check("out", 272'(bus.out), 272'(exp_out));
      check("busy_at_done", 272'(bus.busy), 272'(1'b0));
      check("ffa_pulses", 272'(pulse_cnt), 272'(exp_ops));
      check("operand_stable", 272'(stab_viol), 272'(0));
      check("no_overlap", 272'(overlap_viol), 272'(0));
      $display("op k=%0d x=%0h out=%0h ffa_ops=%0d", k, x, bus.out, pulse_cnt);
      @(negedge clk);
      check("done_one_cycle", 272'(bus.done), 272'(1'b0));
      check("out_held", 272'(bus.out), 272'(exp_out));
   endtask

   initial begin
      logic [254:0] pm1;
      logic [254:0] x254;
      int           n;
      pm1  = P[254:0] - 255'd1;
      x254 = 255'd1 << 254;
      bus.start = 1'b0;
      bus.k     = '0;
      bus.x     = '0;
      repeat (3) @(negedge clk);
      check("rst_out", 272'(bus.out), 272'(0));
      check("rst_done", 272'(bus.done), 272'(0));
      check("rst_busy", 272'(bus.busy), 272'(0));
      check("rst_ffa_start", 272'(bus.ffa_start), 272'(0));
      check("rst_ffa_a", 272'(bus.ffa_a), 272'(0));
      check("rst_ffa_b", 272'(bus.ffa_b), 272'(0));
      rst = 1'b0;

      run_op(8'd1, 255'd5, 1'b0);
      run_op(8'd0, 255'd5, 1'b0);
      run_op(8'd3, pm1, 1'b0);
      run_op(8'd8, x254, 1'b0);
      run_op(8'd255, 255'd1, 1'b0);

      // Reset while the adder is in flight for k=255.
      @(negedge clk);
      bus.start = 1'b1;
      bus.k     = 8'd255;
      bus.x     = 255'd1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.ffa_start !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ffa_start_seen", 272'(n < 100), 272'(1'b1));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_out", 272'(bus.out), 272'(0));
      check("midrst_done", 272'(bus.done), 272'(0));
      check("midrst_busy", 272'(bus.busy), 272'(0));
      check("midrst_ffa_start", 272'(bus.ffa_start), 272'(0));
      check("midrst_ffa_a", 272'(bus.ffa_a), 272'(0));
      check("midrst_ffa_b", 272'(bus.ffa_b), 272'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_rst", 272'(bus.busy), 272'(0));

      run_op(8'd2, 255'd7, 1'b1);

      for (int i = 0; i < 25; i++) begin
         run_op(KW'($urandom), rand_fe(), (i % 4) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
